// File: rtl/arb2to1_if.sv
// rtl/arb2to1_if.sv - valid/ready/last stream channel used by the arb2to1 sources and output
interface arb2to1_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/arb2to1.sv
// rtl/arb2to1.sv - two-input round-robin stream arbiter with registered output and mux select
// Optional packet locking enabled by defining ARB2_LOCK_EN.
module arb2to1 #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  arb2to1_if.slave  a,
  arb2to1_if.slave  b,
  arb2to1_if.master f,
  output logic      sel,
  output logic      busy
);

  logic             r_f_valid;
  logic [WIDTH-1:0] r_f_data;
  logic             r_f_last;
  logic             r_sel;
  logic             r_prio;

  logic             w_load;
  logic             w_gnt;
  logic             w_idx;
  logic             w_acc;
  logic             w_last;
  logic [WIDTH-1:0] w_data;

`ifdef ARB2_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
  state_t r_state;
  logic   r_owner;
  logic   r_busy;
`endif

  // Index defaults to B only when B alone is valid; with neither valid w_gnt is 0.
  always_comb begin
    w_gnt = a.valid || b.valid;
    w_idx = (a.valid && b.valid) ? r_prio : b.valid;
`ifdef ARB2_LOCK_EN
    if (r_state == LOCK) begin
      w_idx = r_owner;
      w_gnt = r_owner ? b.valid : a.valid;
    end
`endif
  end

  assign w_load  = !r_f_valid || f.ready;
  assign w_acc   = w_load && w_gnt && !rst;
  assign w_data  = w_idx ? b.data : a.data;
  assign w_last  = w_idx ? b.last : a.last;

  assign a.ready = w_acc && !w_idx;
  assign b.ready = w_acc && w_idx;

  assign f.valid = r_f_valid;
  assign f.data  = r_f_data;
  assign f.last  = r_f_last;
  assign sel     = r_sel;

`ifdef ARB2_LOCK_EN
  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_valid <= 1'b0;
      r_f_data  <= '0;
      r_f_last  <= 1'b0;
      r_sel     <= 1'b0;
      r_prio    <= 1'b0;
`ifdef ARB2_LOCK_EN
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_busy    <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_acc) begin
        r_f_valid <= 1'b1;
        r_f_data  <= w_data;
        r_f_last  <= w_last;
        r_sel     <= w_idx;
`ifdef ARB2_LOCK_EN
        // Priority only rotates at packet boundaries so a locked packet never loses its turn.
        if (w_last) begin
          r_prio  <= !w_idx;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state <= LOCK;
          r_owner <= w_idx;
          r_busy  <= 1'b1;
        end
`else
        r_prio    <= !w_idx;
`endif
      end else begin
        r_f_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2to1.sv
// tb/tb_arb2to1.sv - self-checking bench for arb2to1: vector table, packet sequence, random vs model
module tb_arb2to1;

  logic clk;
  logic rst;
  logic sel;
  logic busy;

  arb2to1_if #(.WIDTH(8)) a_if ();
  arb2to1_if #(.WIDTH(8)) b_if ();
  arb2to1_if #(.WIDTH(8)) f_if ();

  arb2to1 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a_if),
    .b    (b_if),
    .f    (f_if),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       r;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       fr;
    logic       ear;
    logic       ebr;
    logic       efv;
    logic [7:0] efd;
    logic       efl;
    logic       esel;
  } vec_t;

  vec_t vecs[18];

  // reference model state
  logic       m_fv;
  logic [7:0] m_fd;
  logic       m_fl;
  logic       m_sel;
  int         m_prio;
  int         m_owner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl, input logic fr);
    rst        = r;
    a_if.valid = av;
    a_if.data  = ad;
    a_if.last  = al;
    b_if.valid = bv;
    b_if.data  = bd;
    b_if.last  = bl;
    f_if.ready = fr;
  endtask

  logic [7:0] pa_d[3];
  logic       pa_l[3];
  logic [7:0] pb_d[2];
  logic [7:0] exp_d[5];
  logic       exp_l[5];
  logic       exp_b[5];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'hA3, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'hA3, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'hA3, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b1};

    // Table: all beats carry last=1, so expectations hold with or without packet locking.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].r, vecs[i].av, vecs[i].ad, 1'b1, vecs[i].bv, vecs[i].bd, 1'b1, vecs[i].fr);
      #3;
      chk($sformatf("vec%0d_a_ready", i), a_if.ready, vecs[i].ear);
      chk($sformatf("vec%0d_b_ready", i), b_if.ready, vecs[i].ebr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_f_valid", i), f_if.valid, vecs[i].efv);
      chk($sformatf("vec%0d_f_data", i), f_if.data, vecs[i].efd);
      chk($sformatf("vec%0d_f_last", i), f_if.last, vecs[i].efl);
      chk($sformatf("vec%0d_sel", i), sel, vecs[i].esel);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
    end

    // Packet sequence: A sends 3 beats (last on the third), B offers two single-beat packets.
    pa_d = '{8'h31, 8'h32, 8'h33};
    pa_l = '{1'b0, 1'b0, 1'b1};
    pb_d = '{8'h41, 8'h42};
`ifdef ARB2_LOCK_EN
    exp_d = '{8'h31, 8'h32, 8'h33, 8'h41, 8'h42};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_d = '{8'h31, 8'h41, 8'h32, 8'h42, 8'h33};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    begin
      int ia;
      int ib;
      logic ra;
      logic rb;
      ia = 0;
      ib = 0;
      for (int c = 0; c < 5; c++) begin
        drive(1'b0, ia < 3, pa_d[ia < 3 ? ia : 2], pa_l[ia < 3 ? ia : 2],
              ib < 2, pb_d[ib < 2 ? ib : 1], 1'b1, 1'b1);
        #3;
        ra = a_if.ready;
        rb = b_if.ready;
        @(posedge clk);
        #1;
        if (ra) ia++;
        if (rb) ib++;
        chk($sformatf("pkt%0d_f_valid", c), f_if.valid, 1'b1);
        chk($sformatf("pkt%0d_f_data", c), f_if.data, exp_d[c]);
        chk($sformatf("pkt%0d_f_last", c), f_if.last, exp_l[c]);
        chk($sformatf("pkt%0d_busy", c), busy, exp_b[c]);
      end
    end

    // Random traffic against a beat-level model of the arbitration rules.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    m_fv = 1'b0; m_fd = 8'h00; m_fl = 1'b0; m_sel = 1'b0; m_prio = 0; m_owner = -1;
    begin
      logic       pv[2];
      logic [7:0] pd[2];
      logic       pl[2];
      logic       r;
      logic       fr;
      logic       can;
      int         pick;
      logic       er[2];
      pv = '{1'b0, 1'b0};
      pd = '{8'h00, 8'h00};
      pl = '{1'b0, 1'b0};
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < 2; k++) begin
          if (!pv[k] && $urandom_range(0, 3) != 0) begin
            pv[k] = 1'b1;
            pd[k] = 8'($urandom);
            pl[k] = 1'($urandom_range(0, 1));
          end
        end
        fr = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 59) == 0);
        drive(r, pv[0], pd[0], pl[0], pv[1], pd[1], pl[1], fr);

        can  = !m_fv || fr;
        pick = -1;
        if (m_owner >= 0) pick = pv[m_owner] ? m_owner : -1;
        else if (pv[0] && pv[1]) pick = m_prio;
        else if (pv[0]) pick = 0;
        else if (pv[1]) pick = 1;
        for (int k = 0; k < 2; k++) er[k] = can && !r && (pick == k);

        #3;
        chk($sformatf("rnd%0d_a_ready", c), a_if.ready, er[0]);
        chk($sformatf("rnd%0d_b_ready", c), b_if.ready, er[1]);

        if (r) begin
          m_fv = 1'b0; m_fd = 8'h00; m_fl = 1'b0; m_sel = 1'b0; m_prio = 0; m_owner = -1;
        end else if (can) begin
          if (pick >= 0) begin
            m_fv  = 1'b1;
            m_fd  = pd[pick];
            m_fl  = pl[pick];
            m_sel = pick[0];
`ifdef ARB2_LOCK_EN
            if (pl[pick]) begin
              m_owner = -1;
              m_prio  = 1 - pick;
            end else begin
              m_owner = pick;
            end
`else
            m_prio = 1 - pick;
`endif
            pv[pick] = 1'b0;
          end else begin
            m_fv = 1'b0;
          end
        end

        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_f_valid", c), f_if.valid, m_fv);
        chk($sformatf("rnd%0d_f_data", c), f_if.data, m_fd);
        chk($sformatf("rnd%0d_f_last", c), f_if.last, m_fl);
        chk($sformatf("rnd%0d_sel", c), sel, m_sel);
        chk($sformatf("rnd%0d_busy", c), busy, m_owner >= 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb2to1.md
# arb2to1

Two-input round-robin stream arbiter that sits directly upstream of the 2:1 mux stage. It picks one of two valid/ready source channels per beat, drives the `sel` line that steers the mux, and presents the chosen beat on a single registered output channel. Fairness is strict alternation when both sources contend. Optional packet locking holds the grant for the whole packet.

## Interface
- `WIDTH`, 8: data width of each channel.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_valid` input 1: source A beat available.
- `a_data` input WIDTH: source A payload.
- `a_last` input 1: source A final beat of packet; used only with `ARB2_LOCK_EN`.
- `a_ready` output 1: source A beat accepted this cycle.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A signals, for source B.
- `f_valid` output 1: output beat available (registered).
- `f_data` output WIDTH: output payload (registered).
- `f_last` output 1: copy of accepted beat's last flag (registered).
- `f_ready` input 1: downstream accepts output beat.
- `sel` output 1: current grant; 0 = A, 1 = B (registered, drives mux select).
- `busy` output 1: packet lock held; constant 0 without `ARB2_LOCK_EN`.

## Operation
- Output register loads when `load = !f_valid || f_ready`.
- Grant decision, combinational, evaluated every cycle:
  - Only one source valid: grant that source.
  - Both valid: grant the source equal to priority pointer `prio`.
  - Neither valid: no grant.
- `a_ready = load && grant==A && !rst`; `b_ready` is the same for B. At most one ready is high per cycle.
- On acceptance (`x_valid && x_ready`), on the next edge:
  - `f_data`/`f_last` take the source's values.
  - `f_valid` becomes 1.
  - `sel` takes the granted index.
  - `prio` becomes the opposite of the granted index.
- If `load` is true and no acceptance occurs, `f_valid` becomes 0. `f_data`, `sel` and `prio` hold.
- While `f_valid && !f_ready`: output is frozen; `f_data`, `f_last`, `f_valid` and `sel` are stable; no source ready.
- Ungranted source is never dropped. It waits; round-robin guarantees it service within two output beats.

## Timing
- Reset values: `f_valid`=0, `f_data`=0, `f_last`=0, `sel`=0, `prio`=0 (A first), `busy`=0. `a_ready`/`b_ready` are 0 during the reset cycle.
- Latency: a beat accepted at edge N is on `f_*` after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle when `f_ready` is held high.
- `a_ready`/`b_ready` depend combinationally on `f_ready`. The path is `f_ready` to ready, with no loop through valid.
- Reset asserted mid-packet or mid-stall: all state returns to reset values on the next edge. The pending output beat is discarded.
- Both sources are valid the cycle after a stall releases: the grant follows `prio` as it was before the stall.

## Configuration
- `ARB2_LOCK_EN` defined:
  - Two-state FSM, IDLE and LOCK.
  - IDLE to LOCK: on acceptance of a beat with `last`=0; lock owner = granted source.
  - In LOCK: the grant is forced to the owner regardless of `prio` or the other source's valid.
  - LOCK to IDLE: on acceptance of the owner's beat with `last`=1.
  - A beat with `last`=1 accepted in IDLE stays in IDLE.
  - `prio` updates only when a packet ends, i.e. on acceptance of a `last`=1 beat.
  - `busy` = (state==LOCK), registered; reset to IDLE.
- Not defined:
  - Arbitration is per beat; `a_last`/`b_last` are still passed through to `f_last`.
  - `busy` tied 0; no FSM is synthesized.

## Test plan
- Reset, then `a_valid`=1, `a_data`=0x11, `f_ready`=1: `a_ready`=1 for one cycle, then `f_valid`=1, `f_data`=0x11, `sel`=0.
- Both valid continuously (A=0xA0.., B=0xB0..), `f_ready`=1: output alternates A,B,A,B starting with A; `sel` toggles 0,1,0,1; one beat per cycle.
- Stall: `f_valid`=1 with `f_ready`=0 for 3 cycles while both sources are valid: `f_data`/`sel` constant, both readies 0; after release, the next beat comes from the `prio` source.
- `rst` pulsed for 1 cycle while `f_valid`=1 and stalled: next cycle `f_valid`=0, `sel`=0, `f_data`=0; A is then granted first under contention.
- With `ARB2_LOCK_EN`, A sends a 3-beat packet (last on beat 3) while B is valid throughout: output is A,A,A then B; `busy`=1 after beats 1-2 and 0 after beat 3.
- Without `ARB2_LOCK_EN`, same stimulus: output is A,B,A,B; `busy` stays 0; `f_last` follows each beat.
